// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the register-file stage and the data-memory
// load/store unit. The core side is the master; the memory unit is the slave.
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  op;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        misaligned;
    logic        busy;

    modport master (
        output req_valid, op, daddr, wdata,
        input  req_ready, rsp_valid, rdata, misaligned, busy
    );

    modport slave (
        input  req_valid, op, daddr, wdata,
        output req_ready, rsp_valid, rdata, misaligned, busy
    );
endinterface

// File: rtl/dmem_lsu.sv
// Multi-cycle byte/half/word load/store unit over a little-endian word memory.
// One access in flight; commit and array read happen LATENCY cycles after acceptance.
module dmem_lsu #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic       clk,
    input  logic       reset,
    dmem_lsu_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = ($clog2(LATENCY + 1) > 2) ? $clog2(LATENCY + 1) : 2;
    localparam logic [CW-1:0] LAT_C = CW'(LATENCY);

    localparam logic [5:0] OP_LB  = 6'd19;
    localparam logic [5:0] OP_LH  = 6'd20;
    localparam logic [5:0] OP_LW  = 6'd21;
    localparam logic [5:0] OP_LBU = 6'd22;
    localparam logic [5:0] OP_LHU = 6'd23;
    localparam logic [5:0] OP_SB  = 6'd24;
    localparam logic [5:0] OP_SH  = 6'd25;
    localparam logic [5:0] OP_SW  = 6'd26;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [5:0]      op_reg;
    logic [AW+1:0]   addr_reg;
    logic [31:0]     wdata_reg;
    logic            rsp_reg, mis_reg;

    logic            valid_op, accept, fire;
    logic [5:0]      acc_op;
    logic [AW+1:0]   acc_addr;
    logic [31:0]     acc_wdata;
    logic            acc_mis;
    logic [3:0]      acc_be;
    logic [31:0]     acc_lane_data;
    logic [31:0]     word_rd;
    logic [31:0]     load_data;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic            unused_daddr;

    assign unused_daddr = ^bus.daddr[31:AW+2];

    assign valid_op = (bus.op >= OP_LB) && (bus.op <= OP_SW);
    assign accept   = (state_reg == IDLE) && bus.req_valid && valid_op;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        fire       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_next = RESP;
                        fire       = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CW'(1);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == LAT_C) begin
                    state_next = RESP;
                    cnt_next   = '0;
                    fire       = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // With LATENCY=0 the commit coincides with acceptance, so the live request is used.
    assign acc_op    = (state_reg == IDLE) ? bus.op : op_reg;
    assign acc_addr  = (state_reg == IDLE) ? bus.daddr[AW+1:0] : addr_reg;
    assign acc_wdata = (state_reg == IDLE) ? bus.wdata : wdata_reg;

    always_comb begin
        acc_mis       = 1'b0;
        acc_be        = 4'b0000;
        acc_lane_data = acc_wdata;
        case (acc_op)
            OP_LH, OP_LHU: acc_mis = acc_addr[0];
            OP_LW:         acc_mis = (acc_addr[1:0] != 2'b00);
            OP_SB: begin
                acc_be        = 4'b0001 << acc_addr[1:0];
                acc_lane_data = {4{acc_wdata[7:0]}};
            end
            OP_SH: begin
                acc_mis       = acc_addr[0];
                acc_be        = acc_addr[1] ? 4'b1100 : 4'b0011;
                acc_lane_data = {2{acc_wdata[15:0]}};
            end
            OP_SW: begin
                acc_mis = (acc_addr[1:0] != 2'b00);
                acc_be  = 4'b1111;
            end
            default: acc_mis = 1'b0;
        endcase
        if (acc_mis) begin
            acc_be = 4'b0000;
        end
    end

    // One byte-wide array per lane gives a clean byte-enable write with registered read.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS] = '{default: 8'h00};
            logic [7:0] rd_reg;

            always_ff @(posedge clk) begin
                if (!reset && fire) begin
                    if (acc_be[gi]) begin
                        mem[acc_addr[AW+1:2]] <= acc_lane_data[gi*8 +: 8];
                    end
                    rd_reg <= mem[acc_addr[AW+1:2]];
                end
            end

            assign word_rd[gi*8 +: 8] = rd_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rsp_reg   <= 1'b0;
            mis_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                op_reg    <= bus.op;
                addr_reg  <= bus.daddr[AW+1:0];
                wdata_reg <= bus.wdata;
            end
            rsp_reg <= fire;
            mis_reg <= fire & acc_mis;
        end
    end

    always_comb begin
        sel_half = addr_reg[1] ? word_rd[31:16] : word_rd[15:0];
        case (addr_reg[1:0])
            2'd0:    sel_byte = word_rd[7:0];
            2'd1:    sel_byte = word_rd[15:8];
            2'd2:    sel_byte = word_rd[23:16];
            default: sel_byte = word_rd[31:24];
        endcase
        case (op_reg)
            OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_data = {24'h0, sel_byte};
            OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_data = {16'h0, sel_half};
            OP_LW:   load_data = word_rd;
            default: load_data = 32'h0;
        endcase
    end

    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.busy       = (state_reg != IDLE);
    assign bus.rsp_valid  = rsp_reg;
    assign bus.misaligned = mis_reg;
    assign bus.rdata      = (rsp_reg && !mis_reg) ? load_data : 32'h0;
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Multi-cycle load/store responder for the RISC-V datapath. Consumes the effective address `daddr` and store operand produced by the register-file stage. Performs byte/half/word accesses on a word-organised little-endian data memory and returns sign- or zero-extended load data through a valid/ready handshake. The core stalls on `busy` while an access is outstanding.

## Interface
- `DEPTH_WORDS`, default 1024: data memory size in 32-bit words; power of two.
- `LATENCY`, default 2: wait cycles between request acceptance and memory commit/response; 0 is legal.
- `clk` input, 1 bit: clock; all state changes on posedge.
- `reset` input, 1 bit: synchronous, active-high; sampled on posedge `clk`.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: block can accept a request this cycle.
- `op` input, 6 bits: 19 LB, 20 LH, 21 LW, 22 LBU, 23 LHU, 24 SB, 25 SH, 26 SW; other values are not memory ops.
- `daddr` input, 32 bits: byte address.
- `wdata` input, 32 bits: store operand (rv2); low byte/half used for SB/SH.
- `rsp_valid` output, 1 bit: response valid, one-cycle pulse.
- `rdata` output, 32 bits: extended load data; 0 for stores and faults.
- `misaligned` output, 1 bit: qualifies `rsp_valid`; access faulted, memory untouched.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- States are IDLE, WAIT and RESP. A 2-bit-minimum counter counts the LATENCY cycles in WAIT.
- IDLE: `req_ready`=1. On `req_valid`=1 with op in 19..26, the block latches op, daddr and wdata. It then goes to WAIT, or straight to RESP if LATENCY=0.
- IDLE with `req_valid`=1 and op outside 19..26: the request is ignored, no response, stay in IDLE.
- WAIT: when the counter reaches LATENCY, go to RESP. Input changes in WAIT are ignored; only latched fields are used.
- RESP: `rsp_valid`=1 for one cycle, then IDLE. Back-to-back requests are accepted only in IDLE.
- Word index is latched daddr[log2(DEPTH_WORDS)+1:2]. Upper address bits are discarded, so addresses wrap modulo 4*DEPTH_WORDS.
- Misaligned accesses: LH, LHU or SH with addr[0]=1; LW or SW with addr[1:0]≠0. A misaligned access follows the same timing, with `misaligned`=1, `rdata`=0 and no memory write.
- Loads read the byte lane addr[1:0] or the half lane addr[1] of the addressed word.
  - LB and LH sign-extend from bit 7 or bit 15.
  - LBU and LHU zero-extend.
  - LW returns the whole word.
- Stores use a byte-enable write.
  - SB writes wdata[7:0] into lane addr[1:0].
  - SH writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes. Unselected lanes are preserved.
- Memory contents are initialised to zero at time 0. Reset does not clear memory.

## Timing
- Reset values: state IDLE, counter 0, `req_ready`=1, `busy`=0, `rsp_valid`=0, `rdata`=0, `misaligned`=0.
- Let k be the acceptance edge. The store commit and the load array read occur at edge k+LATENCY. `rsp_valid`, `rdata` and `misaligned` are valid in the cycle after edge k+LATENCY.
- Minimum spacing between accepted requests is LATENCY+2 cycles.
- `rdata` and `misaligned` return to 0 the cycle after `rsp_valid` drops.
- Reset asserted at any edge up to and including k+LATENCY aborts the access: no memory write, no response, state IDLE next cycle.
- Reset asserted during RESP: the pulse ends, outputs go to their reset values.
- `req_valid` held high through a response: the next request is accepted at the edge where the state is IDLE, not in RESP.
- A load issued immediately after a store to the same word returns the updated data.

## Test plan
- LATENCY=2: SW 0xDEADBEEF at 0x100, then LW 0x100 -> `rsp_valid` 3 cycles after acceptance of each request, with `rdata`=0x00000000 for the SW and 0xDEADBEEF for the LW.
- After the above, run LB, LBU, LH and LHU on 0x103, 0x103, 0x102 and 0x102:
  - LB -> 0xFFFFFFDE
  - LBU -> 0x000000DE
  - LH -> 0xFFFFDEAD
  - LHU -> 0x0000DEAD
- SB 0x55 at 0x101, then LW 0x100 -> 0xDEAD55EF. Then SH 0x1234 at 0x102 and LW 0x100 -> 0x123455EF.
- SW at 0x102 (misaligned), then LW 0x100 -> first response has `misaligned`=1 and `rdata`=0; second response returns the memory unchanged, 0x123455EF.
- Reset pulse at edge k+1 during SW 0xFFFFFFFF to 0x200 -> no `rsp_valid`, `busy`=0 next cycle; a subsequent LW 0x200 returns 0.
- DEPTH_WORDS=1024: SW 0xA5A5A5A5 at 0x1000, then LW 0x0 -> 0xA5A5A5A5 (wrap-around). op=5 with `req_valid` held 4 cycles -> no response, `busy` stays 0.
